load_store_unit: RTL and testbench

Memory-stage load/store unit sitting directly downstream of the execute-stage ALU. It takes the registered ALU result as the effective address and issues one data-memory transaction per request over a valid/ready-style handshake. Store data is lane-aligned with byte strobes; load data is extracted and sign/zero-extended. A one-cycle `done` pulse signals completion to the writeback/control logic.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 93 +++++++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: RV32I funct3
//               width codes for loads and stores, and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Transaction FSM states (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational lane logic for the load/store unit.
//               - store: replicates byte/half across lanes, builds strobes
//               - load : extracts byte/half/word and sign/zero-extends it
//               - flags illegal funct3 codes (and misaligned accesses when
//                 LSU_MISALIGN_TRAP_EN is defined)
// Ports       : is_store, funct3, lane (addr[1:0]), store_data, rdata in;
//               wdata, wstrb, load_value, illegal out.
// Config      : LSU_MISALIGN_TRAP_EN - treat misaligned half/word as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_value,
  output logic        illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bad_funct3;

  // Halfword lane ignores addr[0]; only the trap build cares about it.
  assign w_half = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (lane)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
  end

  always_comb begin
    wdata        = store_data;
    wstrb        = 4'b0000;
    load_value   = rdata;
    w_bad_funct3 = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wdata = {4{store_data[7:0]}};
          wstrb = 4'b0001 << lane;
        end
        F3_SH: begin
          wdata = {2{store_data[15:0]}};
          wstrb = lane[1] ? 4'b1100 : 4'b0011;
        end
        F3_SW:   wstrb = 4'b1111;
        default: w_bad_funct3 = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB:   load_value = {{24{w_byte[7]}}, w_byte};
        F3_LBU:  load_value = {24'd0, w_byte};
        F3_LH:   load_value = {{16{w_half[15]}}, w_half};
        F3_LHU:  load_value = {16'd0, w_half};
        F3_LW:   load_value = rdata;
        default: w_bad_funct3 = 1'b1;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misaligned;

  // funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    w_misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   w_misaligned = lane[0];
      2'b10:   w_misaligned = |lane;
      default: w_misaligned = 1'b0;
    endcase
  end

  assign illegal = w_bad_funct3 | w_misaligned;
`else
  assign illegal = w_bad_funct3;
`endif

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage load/store unit. Latches one request from the
//               control path, issues a single data-memory transaction over a
//               req/ready handshake, and pulses done (with fault on abort).
// Ports       : clk, rst (sync, active-high); start, is_store, funct3, addr,
//               store_data from control; busy, done, fault, load_data to
//               writeback; mem_req/we/addr/wdata/wstrb, mem_ready/rdata to
//               data memory.
// Params      : TIMEOUT_CYCLES - REQ cycles allowed without mem_ready
//               (0 disables the timeout).
// Config      : LSU_MISALIGN_TRAP_EN - fault misaligned half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int         CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit         c_TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] c_TMO_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e r_state, w_next_state;

  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_lane;
  logic [CNT_W-1:0] r_tmo_cnt;

  logic             w_sel_is_store;
  logic [2:0]       w_sel_funct3;
  logic [1:0]       w_sel_lane;
  logic [31:0]      w_wdata;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_load_value;
  logic             w_illegal;
  logic             w_accept;
  logic             w_timeout;

  // The aligner decodes the live request while idle (to choose REQ/FAULT
  // and precompute store lanes) and the latched request afterwards (to
  // extract load data on mem_ready).
  assign w_sel_is_store = (r_state == ST_IDLE) ? is_store   : r_is_store;
  assign w_sel_funct3   = (r_state == ST_IDLE) ? funct3     : r_funct3;
  assign w_sel_lane     = (r_state == ST_IDLE) ? addr[1:0]  : r_lane;

  lsu_align u_align (
    .is_store   (w_sel_is_store),
    .funct3     (w_sel_funct3),
    .lane       (w_sel_lane),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .wdata      (w_wdata),
    .wstrb      (w_wstrb),
    .load_value (w_load_value),
    .illegal    (w_illegal)
  );

  assign w_accept  = (r_state == ST_IDLE) && start;
  // Fires on the last permitted REQ cycle; a late mem_ready still wins.
  assign w_timeout = c_TMO_EN && (r_tmo_cnt == c_TMO_LAST) && !mem_ready;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = w_illegal ? ST_FAULT : ST_REQ;
      end
      ST_REQ: begin
        if (mem_ready)      w_next_state = ST_RESP;
        else if (w_timeout) w_next_state = ST_FAULT;
      end
      ST_RESP:  w_next_state = ST_IDLE;
      ST_FAULT: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // ---------------- state-decoded outputs ----------------
  always_comb begin
    mem_req = (r_state == ST_REQ);
    mem_we  = (r_state == ST_REQ) && r_is_store;
    busy    = (r_state != ST_IDLE);
    done    = (r_state == ST_RESP) || (r_state == ST_FAULT);
    fault   = (r_state == ST_FAULT);
  end

  // ---------------- request / response datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'd0;
      r_lane     <= 2'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'b0000;
      load_data  <= 32'd0;
      r_tmo_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_is_store <= is_store;
        r_funct3   <= funct3;
        r_lane     <= addr[1:0];
        mem_addr   <= {addr[31:2], 2'b00};
        mem_wdata  <= w_wdata;
        mem_wstrb  <= w_wstrb;
      end

      // Written on the accepting edge so the value is valid alongside done.
      if ((r_state == ST_REQ) && mem_ready && !r_is_store)
        load_data <= w_load_value;

      if ((r_state == ST_REQ) && !mem_ready)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else
        r_tmo_cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Directed cases cover
//               the documented scenarios and boundaries; a randomized phase
//               drives mixed loads/stores with random wait states. Expected
//               values come from an arithmetic reference model.
// Config      : honours LSU_MISALIGN_TRAP_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TMO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_load;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_reject(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (st && f3 > 3'd2) return 1'b1;
    if (!st && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    size = 1 << f3[1:0];
    return TRAP && ((a % size) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int b;
    int h;
    b = int'((rd >> (8 * (a % 4))) & 32'hFF);
    h = int'((rd >> (16 * ((a / 2) % 2))) & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd5:    return 32'(h);
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_wstrb(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (!st) return 32'd0;
    case (f3)
      3'd0:    return 32'd1 << (a % 4);
      3'd1:    return (((a / 2) % 2) != 0) ? 32'd12 : 32'd3;
      default: return 32'd15;
    endcase
  endfunction

  // One transaction starting at a negedge in IDLE; returns at a negedge in IDLE.
  // waits >= TMO means the memory never answers. poke re-pulses start while busy.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int waits,
                         input bit poke);
    bit rej;
    bit tmo;
    int exp_lat;
    int reqn;
    bit seen;
    rej     = ref_reject(st, f3, a);
    tmo     = !rej && (waits >= TMO);
    exp_lat = rej ? 1 : (tmo ? TMO + 1 : waits + 2);
    reqn    = 0;
    seen    = 1'b0;

    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d; mem_rdata = rd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (cyc == 1) begin
        // Scramble the request inputs: the DUT must use its latched copy.
        start = poke; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom;
      end else begin
        start = 1'b0;
      end
      if (rej) check("no_req_on_fault", 32'(mem_req), 32'd0);
      if (mem_req) begin
        check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("mem_we", 32'(mem_we), 32'(st));
        check("mem_wstrb", 32'(mem_wstrb), ref_wstrb(st, f3, a));
        if (st) check("mem_wdata", mem_wdata, ref_wdata(f3, d));
        check("busy_req", 32'(busy), 32'd1);
        mem_ready = (reqn == waits);
        reqn++;
      end
      if (done) begin
        check("latency", 32'(cyc), 32'(exp_lat));
        check("fault", 32'(fault), 32'(rej || tmo));
        if (!st && !rej && !tmo) model_load = ref_load(f3, a, rd);
        check("load_data", load_data, model_load);
        check("req_cycles", 32'(reqn), 32'(rej ? 0 : (tmo ? TMO : waits + 1)));
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    mem_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("done_pulse_1cyc", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("req_after_done", 32'(mem_req), 32'd0);
    if (poke) begin
      repeat (3) begin
        @(negedge clk);
        check("poke_ignored_req", 32'(mem_req), 32'd0);
        check("poke_ignored_done", 32'(done), 32'd0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_req"},   32'(mem_req), 32'd0);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_addr"},  mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, "_ldata"}, load_data, 32'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
    store_data = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0; model_load = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios
    run_txn(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);           // SW
    run_txn(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 0, 1'b0);           // SB lane 3
    run_txn(1'b0, 3'd0, 32'h202, 32'h0, 32'h1180_2233, 0, 1'b0);           // LB -> FFFFFF80
    run_txn(1'b0, 3'd4, 32'h202, 32'h0, 32'h1180_2233, 1, 1'b0);           // LBU -> 00000080
    run_txn(1'b0, 3'd1, 32'h201, 32'h0, 32'h1180_2233, 0, 1'b0);           // LH misaligned
    run_txn(1'b1, 3'd1, 32'h302, 32'h1234_5678, 32'h0, 2, 1'b0);           // SH upper half
    run_txn(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFE_F00D, TMO - 1, 1'b0);     // ready on last cycle
    run_txn(1'b0, 3'd2, 32'h304, 32'h0, 32'h0BAD_0BAD, TMO + 5, 1'b0);     // timeout
    run_txn(1'b0, 3'd3, 32'h400, 32'h0, 32'h5555_5555, 0, 1'b0);           // illegal load
    run_txn(1'b1, 3'd3, 32'h404, 32'h1, 32'h0, 0, 1'b0);                   // illegal store
    run_txn(1'b0, 3'd5, 32'h502, 32'h0, 32'h8001_7FFF, 2, 1'b1);           // start while busy

    // Reset in the middle of a stalled REQ
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h600; mem_rdata = 32'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("req_before_rst", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    model_load = 32'd0;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 32'd0);
    end

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      w = ($urandom_range(0, 15) == 0) ? TMO : int'($urandom_range(0, 3));
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, w, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
